// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the two-requester I2C master bus arbiter.
package i2c_arb_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 100_000;

  // Requester index: 0 or 1.
  typedef logic owner_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_OWN,
    S_STOP_WAIT,
    S_ABORT,
    S_ABORT_WAIT,
    S_RELEASE
  } state_t;

  function automatic logic [1:0] owner_onehot(input owner_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/i2c_arb_watchdog.sv
// Owner-inactivity counter: clears on request, saturates at TIMEOUT_CYCLES-1 and
// flags expiry there, so it never wraps back to an idle-looking value.
module i2c_arb_watchdog
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int            CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LIMIT);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Arbitrates two requesters onto one I2C master: round-robin grant, transparent
// routing while owned, and a watchdog that forces a STOP on an idle owner.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [1:0]      req_en,
  input  logic [1:0]      req_start,
  input  logic [1:0]      req_stop,
  input  logic [1:0][7:0] req_tx_data,
  output logic [1:0]      req_tx_ready,
  output logic [1:0]      gnt,
  output logic            I2C_EN,
  output logic            I2C_START,
  output logic            I2C_STOP,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            busy,
  output logic [1:0]      err_timeout,
  input  logic            err_clr
);

  state_t     r_state;
  state_t     w_next;
  owner_t     r_owner;
  owner_t     r_last_owner;
  owner_t     w_pick;
  logic [1:0] r_err;
  logic [1:0] w_err_set;
  logic       w_abort;
  logic       w_wd_clr;
  logic       w_wd_inc;
  logic       w_wd_expired;

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_next  = r_state;
    w_pick  = r_owner;
    w_abort = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|req_en) begin
          w_next = S_GRANT;
          w_pick = (req_en == 2'b11) ? ~r_last_owner : req_en[1];
        end
      end
      S_GRANT: w_next = S_OWN;
      S_OWN: begin
        if (!req_en[r_owner]) begin
          w_next = S_RELEASE;
        end else if (req_stop[r_owner]) begin
          w_next = S_STOP_WAIT;
        end else if (w_wd_expired) begin
          w_next  = S_ABORT;
          w_abort = 1'b1;
        end
      end
      S_STOP_WAIT: begin
        if (tx_ready) begin
          w_next = S_RELEASE;
        end else if (w_wd_expired) begin
          w_next  = S_ABORT;
          w_abort = 1'b1;
        end
      end
      S_ABORT:      w_next = S_ABORT_WAIT;
      S_ABORT_WAIT: if (tx_ready || w_wd_expired) w_next = S_RELEASE;
      S_RELEASE:    w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  assign w_err_set = w_abort ? owner_onehot(r_owner) : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_err        <= '0;
    end else begin
      r_state <= w_next;
      r_owner <= w_pick;
      if (r_state == S_RELEASE) r_last_owner <= r_owner;
      // A timeout landing in the same cycle as err_clr must survive the clear.
      r_err <= (err_clr ? 2'b00 : r_err) | w_err_set;
    end
  end

  // Leaving S_GRANT / S_ABORT restarts the count for the state being entered.
  assign w_wd_clr = (r_state == S_GRANT) || (r_state == S_ABORT) || tx_ready;
  assign w_wd_inc = (r_state == S_OWN) || (r_state == S_STOP_WAIT) || (r_state == S_ABORT_WAIT);

  i2c_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (w_wd_clr),
    .inc    (w_wd_inc),
    .expired(w_wd_expired)
  );

  always_comb begin
    gnt          = 2'b00;
    req_tx_ready = 2'b00;
    I2C_EN       = 1'b0;
    I2C_START    = 1'b0;
    I2C_STOP     = 1'b0;
    tx_data      = 8'h00;
    unique case (r_state)
      S_GRANT: gnt = owner_onehot(r_owner);
      S_OWN, S_STOP_WAIT: begin
        gnt          = owner_onehot(r_owner);
        req_tx_ready = tx_ready ? owner_onehot(r_owner) : 2'b00;
        I2C_EN       = req_en[r_owner];
        I2C_START    = req_start[r_owner];
        I2C_STOP     = req_stop[r_owner];
        tx_data      = req_tx_data[r_owner];
      end
      S_ABORT: begin
        I2C_EN   = 1'b1;
        I2C_STOP = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign err_timeout = r_err;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed scenarios plus randomized traffic, each cycle compared against a
// phase-level reference model of the arbiter kept in this bench.
module tb_i2c_bus_arbiter;

  localparam int T = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      req_en, req_start, req_stop;
  logic [1:0][7:0] req_tx_data;
  logic [1:0]      req_tx_ready, gnt;
  logic            I2C_EN, I2C_START, I2C_STOP;
  logic [7:0]      tx_data;
  logic            tx_ready, busy, err_clr;
  logic [1:0]      err_timeout;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_en      (req_en),
    .req_start   (req_start),
    .req_stop    (req_stop),
    .req_tx_data (req_tx_data),
    .req_tx_ready(req_tx_ready),
    .gnt         (gnt),
    .I2C_EN      (I2C_EN),
    .I2C_START   (I2C_START),
    .I2C_STOP    (I2C_STOP),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next-cycle stimulus, applied together just after a falling edge.
  logic       n_rst, n_txr, n_clr;
  logic [1:0] n_en, n_st, n_sp;
  logic [7:0] n_d0, n_d1;

  // Reference model: bus phase, owner, cycles since last watchdog restart.
  typedef enum int {PH_FREE, PH_GRANTED, PH_ACTIVE, PH_STOPPING, PH_KILL, PH_DRAIN, PH_GAP} phase_e;
  phase_e   m_ph;
  int       m_owner, m_last, m_age;
  bit [1:0] m_err;

  task automatic model_reset();
    m_ph = PH_FREE; m_owner = 0; m_last = 1; m_age = 0; m_err = 2'b00;
  endtask

  task automatic model_step();
    bit     expired, set_err, counting;
    int     new_age;
    phase_e nxt;
    expired  = (m_age >= T - 1);
    counting = (m_ph == PH_ACTIVE) || (m_ph == PH_STOPPING) || (m_ph == PH_DRAIN);
    if (tx_ready)      new_age = 0;
    else if (counting) new_age = (m_age + 1 > T - 1) ? T - 1 : m_age + 1;
    else               new_age = m_age;
    set_err = 1'b0;
    nxt     = m_ph;
    case (m_ph)
      PH_FREE: if (req_en != 2'b00) begin
        nxt     = PH_GRANTED;
        m_owner = (req_en == 2'b11) ? 1 - m_last : ((req_en == 2'b01) ? 0 : 1);
      end
      PH_GRANTED: begin nxt = PH_ACTIVE; new_age = 0; end
      PH_ACTIVE: begin
        if (!req_en[m_owner])     nxt = PH_GAP;
        else if (req_stop[m_owner]) nxt = PH_STOPPING;
        else if (expired)         begin nxt = PH_KILL; set_err = 1'b1; end
      end
      PH_STOPPING: begin
        if (tx_ready)     nxt = PH_GAP;
        else if (expired) begin nxt = PH_KILL; set_err = 1'b1; end
      end
      PH_KILL:  begin nxt = PH_DRAIN; new_age = 0; end
      PH_DRAIN: if (tx_ready || expired) nxt = PH_GAP;
      PH_GAP:   begin nxt = PH_FREE; m_last = m_owner; end
      default:  nxt = PH_FREE;
    endcase
    if (err_clr) m_err = 2'b00;
    if (set_err) m_err[m_owner] = 1'b1;
    m_ph  = nxt;
    m_age = new_age;
  endtask

  task automatic check_outputs();
    logic [1:0] e_gnt, e_rtr;
    logic       e_en, e_st, e_sp;
    logic [7:0] e_d;
    e_gnt = 2'b00; e_rtr = 2'b00; e_en = 1'b0; e_st = 1'b0; e_sp = 1'b0; e_d = 8'h00;
    if (m_ph inside {PH_GRANTED, PH_ACTIVE, PH_STOPPING}) e_gnt = 2'(1 << m_owner);
    if (m_ph inside {PH_ACTIVE, PH_STOPPING}) begin
      e_en  = req_en[m_owner];
      e_st  = req_start[m_owner];
      e_sp  = req_stop[m_owner];
      e_d   = req_tx_data[m_owner];
      e_rtr = tx_ready ? 2'(1 << m_owner) : 2'b00;
    end
    if (m_ph == PH_KILL) begin e_en = 1'b1; e_sp = 1'b1; end
    check("m_gnt",      gnt,          e_gnt);
    check("m_busy",     busy,         m_ph != PH_FREE);
    check("m_i2c_en",   I2C_EN,       e_en);
    check("m_i2c_start", I2C_START,   e_st);
    check("m_i2c_stop", I2C_STOP,     e_sp);
    check("m_tx_data",  tx_data,      e_d);
    check("m_req_rdy",  req_tx_ready, e_rtr);
    check("m_err",      err_timeout,  m_err);
  endtask

  // One clock cycle: drive after the falling edge, compare, advance the model.
  task automatic step();
    @(negedge clk);
    reset_n     = n_rst;
    req_en      = n_en;
    req_start   = n_st;
    req_stop    = n_sp;
    req_tx_data = {n_d1, n_d0};
    tx_ready    = n_txr;
    err_clr     = n_clr;
    #1;
    if (!reset_n) model_reset();
    check_outputs();
    if (reset_n) model_step();
  endtask

  task automatic quiet();
    n_en = 2'b00; n_st = 2'b00; n_sp = 2'b00; n_txr = 1'b0; n_clr = 1'b0;
  endtask

  logic [7:0] bytes_seq [3] = '{8'h42, 8'h12, 8'h80};

  initial begin
    quiet();
    n_rst = 1'b0; n_d0 = 8'h00; n_d1 = 8'h00;
    reset_n = 1'b0; req_en = '0; req_start = '0; req_stop = '0; req_tx_data = '0;
    tx_ready = 1'b0; err_clr = 1'b0;
    model_reset();

    step(); step();
    check("rst_gnt",  gnt,         2'b00);
    check("rst_busy", busy,        1'b0);
    check("rst_err",  err_timeout, 2'b00);
    check("rst_en",   I2C_EN,      1'b0);
    n_rst = 1'b1;
    step();

    // Single requester, routing and byte stream followed by a normal stop.
    n_en = 2'b01; n_d0 = 8'hA5; n_d1 = 8'h3C;
    step();
    step();
    check("s1_gnt", gnt, 2'b01);
    check("s1_grant_en_low", I2C_EN, 1'b0);
    n_st = 2'b01; n_txr = 1'b1;
    step();
    check("s1_tx_data", tx_data, 8'hA5);
    check("s1_rdy_other", req_tx_ready[1], 1'b0);
    check("s1_rdy_owner", req_tx_ready[0], 1'b1);
    n_st = 2'b00; n_txr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_d0 = bytes_seq[i]; n_txr = 1'b0;
      step();
      check("s3_byte", tx_data, bytes_seq[i]);
      n_txr = 1'b1;
      step();
    end
    n_txr = 1'b0; n_sp = 2'b01;
    step();
    step();
    check("s3_stop_wait_stop", I2C_STOP, 1'b1);
    n_txr = 1'b1;
    step();
    quiet();
    step();
    check("s3_release_gnt", gnt, 2'b00);
    step();
    check("s3_busy_fell", busy, 1'b0);

    // Tie after reset goes to requester 0, then to requester 1.
    n_rst = 1'b0; step();
    n_rst = 1'b1; n_en = 2'b11;
    step();
    step();
    check("s2_tie_first", gnt, 2'b01);
    n_sp = 2'b01;
    step();
    n_txr = 1'b1;
    step();
    n_sp = 2'b00; n_txr = 1'b0;
    step();
    step();
    step();
    check("s2_tie_second", gnt, 2'b10);
    n_en = 2'b00;
    step(); step(); step();

    // Watchdog abort after T silent cycles of ownership.
    n_en = 2'b01; n_d0 = 8'h5A;
    step();
    step();
    for (int k = 1; k <= T; k++) begin
      step();
      check("wd_not_early", I2C_STOP, 1'b0);
    end
    step();
    check("wd_abort_stop", I2C_STOP,    1'b1);
    check("wd_abort_en",   I2C_EN,      1'b1);
    check("wd_abort_gnt",  gnt,         2'b00);
    check("wd_abort_data", tx_data,     8'h00);
    check("wd_abort_err",  err_timeout, 2'b01);
    step();
    check("wd_stop_pulse", I2C_STOP, 1'b0);
    n_txr = 1'b1;
    step();
    quiet();
    step();
    check("wd_release_gnt", gnt, 2'b00);
    step();
    check("wd_idle", busy, 1'b0);
    check("wd_err_sticky", err_timeout, 2'b01);

    // Clear racing a timeout set: the set wins, a later clear takes.
    n_clr = 1'b1; step(); n_clr = 1'b0;
    n_en = 2'b10;
    step();
    step();
    for (int k = 1; k <= T; k++) begin
      if (k == T) n_clr = 1'b1;
      step();
    end
    step();
    check("clr_race_set_wins", err_timeout, 2'b10);
    n_clr = 1'b0;
    step();
    check("clr_next_cycle", err_timeout, 2'b00);
    n_en = 2'b00;
    for (int k = 0; k < 18; k++) step();
    check("abort_wait_expiry_idle", busy, 1'b0);

    // Asynchronous reset in the middle of a stop wait.
    n_en = 2'b01; n_d0 = 8'hC3;
    step();
    step();
    n_sp = 2'b01;
    step();
    step();
    #2;
    reset_n = 1'b0; n_rst = 1'b0;
    #1;
    check("arst_gnt",  gnt,         2'b00);
    check("arst_busy", busy,        1'b0);
    check("arst_en",   I2C_EN,      1'b0);
    check("arst_stop", I2C_STOP,    1'b0);
    check("arst_data", tx_data,     8'h00);
    check("arst_err",  err_timeout, 2'b00);
    model_reset();
    n_sp = 2'b00; n_en = 2'b11;
    step();
    n_rst = 1'b1;
    step();
    step();
    check("arst_first_tie", gnt, 2'b01);

    // Randomized traffic with varying master responsiveness.
    for (int seg = 0; seg < 12; seg++) begin
      int txr_pct;
      txr_pct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 5 : 30);
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 9) == 0) n_en = 2'($urandom);
        n_st  = 2'($urandom);
        n_sp  = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
        n_d0  = 8'($urandom);
        n_d1  = 8'($urandom);
        n_txr = ($urandom_range(0, 99) < txr_pct);
        n_clr = ($urandom_range(0, 31) == 0);
        n_rst = ($urandom_range(0, 999) != 0);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
